// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared flag indices, FSM encoding and flag builder for seq_comparator
package cmp_pkg;

    localparam int FLAGS_W = 6;

    localparam int FLG_GT = 0;
    localparam int FLG_LT = 1;
    localparam int FLG_GE = 2;
    localparam int FLG_LE = 3;
    localparam int FLG_EQ = 4;
    localparam int FLG_NE = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // Full flag set derived from the two primary relations; eq is implied by neither.
    function automatic logic [FLAGS_W-1:0] make_flags(input logic gt, input logic lt);
        logic [FLAGS_W-1:0] f;
        logic               eq;
        eq        = ~gt & ~lt;
        f         = '0;
        f[FLG_GT] = gt;
        f[FLG_LT] = lt;
        f[FLG_GE] = gt | eq;
        f[FLG_LE] = lt | eq;
        f[FLG_EQ] = eq;
        f[FLG_NE] = ~eq;
        return f;
    endfunction

endpackage

// File: rtl/slice_cmp.sv
// rtl/slice_cmp.sv - combinational unsigned magnitude compare of one SLICE-bit slice
module slice_cmp #(
    parameter int SLICE = 2
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    output logic             gt,
    output logic             lt
);

    assign gt = (a > b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_comparator.sv
// rtl/seq_comparator.sv - MSB-first multi-cycle magnitude comparator; CMP_TRISTATE_EN adds oe-gated flags
module seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SLICE = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef CMP_TRISTATE_EN
    input  logic               oe,
`endif
    output logic               busy,
    output logic               done,
    output logic [FLAGS_W-1:0] flags
);

    localparam int N     = WIDTH / SLICE;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(N - 1);
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    state_t               state;
    logic [IDX_W-1:0]     idx;
    logic [WIDTH-1:0]     a_reg;
    logic [WIDTH-1:0]     b_reg;
    logic [FLAGS_W-1:0]   flag_reg;
    logic [SLICE-1:0]     a_sl;
    logic [SLICE-1:0]     b_sl;
    logic                 s_gt;
    logic                 s_lt;

    assign a_sl = a_reg[idx*SLICE +: SLICE];
    assign b_sl = b_reg[idx*SLICE +: SLICE];

    slice_cmp #(.SLICE(SLICE)) u_slice_cmp (
        .a  (a_sl),
        .b  (b_sl),
        .gt (s_gt),
        .lt (s_lt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            flag_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Flipping both sign bits maps two's-complement order onto unsigned order.
                        a_reg <= a ^ (sgn ? MSB_MASK : '0);
                        b_reg <= b ^ (sgn ? MSB_MASK : '0);
                        idx   <= IDX_TOP;
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (s_gt || s_lt || (idx == '0)) begin
                        flag_reg <= make_flags(s_gt, s_lt);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CMP_TRISTATE_EN
    assign flags = oe ? flag_reg : {FLAGS_W{1'bz}};
`else
    assign flags = flag_reg;
`endif

endmodule

// File: tb/tb_seq_comparator.sv
// tb/tb_seq_comparator.sv - directed and random scoreboard bench for seq_comparator
module tb_seq_comparator;

    localparam int WIDTH = 8;
    localparam int SLICE = 2;
    localparam int N     = WIDTH / SLICE;

    typedef struct {
        logic [5:0] f;
        int         lat;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             oe;
    logic             busy;
    logic             done;
    logic [5:0]       flags;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb[$];
    logic [5:0] last_flags  = 6'b0;

    seq_comparator #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
`ifdef CMP_TRISTATE_EN
        .oe    (oe),
`endif
        .busy  (busy),
        .done  (done),
        .flags (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] model_flags(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic s);
        logic gt, lt, eq;
        gt = s ? ($signed(x) > $signed(y)) : (x > y);
        lt = s ? ($signed(x) < $signed(y)) : (x < y);
        eq = (x == y);
        return {~eq, eq, lt | eq, gt | eq, lt, gt};
    endfunction

    function automatic int model_lat(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int s = N - 1; s >= 0; s--)
            if (x[s*SLICE +: SLICE] != y[s*SLICE +: SLICE]) return N - s;
        return N;
    endfunction

    // Called at a negedge; drives start there. inj>0 re-pulses start with a=0 on that scan cycle.
    task automatic do_op(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic s,
                         input logic [5:0] ef, input int el, input int inj);
        exp_t e;
        int   cyc;
        a = xa; b = xb; sgn = s; start = 1'b1;
        sb.push_back('{f: ef, lat: el});
        @(negedge clk);
        start = 1'b0;
        check("busy_scan", 32'(busy), 32'd1);
        check("flags_hold", 32'(flags), 32'(last_flags));
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (cyc == inj) begin
                start = 1'b1; a = '0;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(done), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("flags", 32'(flags), 32'(e.f));
            check("latency", 32'(cyc), 32'(e.lat));
            last_flags = e.f;
        end
        check("busy_done", 32'(busy), 32'd0);
    endtask

    initial begin
        logic [WIDTH-1:0] ra, rb;
        logic             rs;
        int               seen;
        rst_n = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0; oe = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);

        // T1 equal operands
        do_op(8'h5A, 8'h5A, 1'b0, 6'b011100, 4, 0);
`ifdef CMP_TRISTATE_EN
        oe = 1'b0; #1;
        check("oe_off", 32'(flags), {26'b0, 6'bzzzzzz});
        oe = 1'b1; #1;
        check("oe_on", 32'(flags), 32'(6'b011100));
`else
        #1;
        check("driven", 32'(flags), 32'(6'b011100));
`endif
        @(negedge clk);
        // T2 unsigned then signed
        do_op(8'h80, 8'h7F, 1'b0, 6'b100101, 1, 0);
        @(negedge clk);
        do_op(8'h80, 8'h7F, 1'b1, 6'b101010, 1, 0);
        @(negedge clk);
        // T3 then back-to-back start in the done cycle
        do_op(8'h12, 8'h13, 1'b0, 6'b101010, 4, 0);
        do_op(8'hFF, 8'h00, 1'b0, 6'b100101, 1, 0);
        @(negedge clk);
        // T4 start during scan is ignored
        do_op(8'h10, 8'h10, 1'b0, 6'b011100, 4, 2);
        @(negedge clk);

        // T5 reset mid-scan
        a = 8'h01; b = 8'h01; sgn = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        seen = 0;
        repeat (6) begin
            if (done) seen++;
            @(negedge clk);
        end
        check("abort_nodone", 32'(seen), 32'd0);
        last_flags = 6'b0;
        do_op(8'h01, 8'h01, 1'b0, 6'b011100, 4, 0);
        @(negedge clk);

        // Random operands against the bench model
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? ra : ((i % 4 == 1) ? (ra ^ 8'h01) : 8'($urandom));
            rs = 1'($urandom);
            do_op(ra, rb, rs, model_flags(ra, rb, rs), model_lat(ra, rb), 0);
            if (i % 2 == 0) @(negedge clk);
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
